// File: rtl/decode_issue.sv
// Decode/issue stage for the 16-bit WISC core: register file, decode, per-register scoreboard.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into issue and hazard logic.
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] instr_pc,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [2:0]  wb_reg,
    input  logic [15:0] wb_data,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_opcode,
    output logic [1:0]  ex_funct,
    output logic [7:0]  ex_imm,
    output logic [15:0] ex_rs,
    output logic [15:0] ex_rt,
    output logic [15:0] ex_pc,
    output logic        ex_wr_en,
    output logic [2:0]  ex_wr_reg,
    output logic        halted
);

    logic [15:0] rf_q [8];
    logic [7:0]  busy_q, busy_d;
    logic        halted_q;

    logic        ex_valid_q;
    logic [4:0]  ex_opcode_q;
    logic [1:0]  ex_funct_q;
    logic [7:0]  ex_imm_q;
    logic [15:0] ex_rs_q, ex_rt_q, ex_pc_q;
    logic        ex_wr_en_q;
    logic [2:0]  ex_wr_reg_q;

    logic [4:0]  opcode;
    logic [2:0]  rs_idx, rt_idx, dest;
    logic        reads_rs, reads_rt, wr_en;
    logic        rs_clear, rt_clear;
    logic [15:0] rs_val, rt_val;
    logic        raw_hazard, waw_hazard, hazard, issue;

    assign opcode = instr[15:11];
    assign rs_idx = instr[10:8];
    assign rt_idx = instr[7:5];

    // Source-operand usage by opcode.
    always_comb begin
        reads_rs = 1'b1;
        reads_rt = 1'b0;
        case (opcode)
            5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11000: reads_rs = 1'b0;
            default: ;
        endcase
        casez (opcode)
            5'b11001, 5'b11010, 5'b11011, 5'b111??, 5'b10000, 5'b10011: reads_rt = 1'b1;
            default: ;
        endcase
    end

    // Destination register selection; dest is 0 when the instruction writes nothing.
    always_comb begin
        wr_en = 1'b0;
        dest  = 3'd0;
        casez (opcode)
            5'b11001, 5'b11010, 5'b11011, 5'b111??: begin
                wr_en = 1'b1;
                dest  = instr[4:2];
            end
            5'b010??, 5'b101??, 5'b10001: begin
                wr_en = 1'b1;
                dest  = instr[7:5];
            end
            5'b10011, 5'b11000, 5'b10010: begin
                wr_en = 1'b1;
                dest  = instr[10:8];
            end
            5'b00110, 5'b00111: begin
                wr_en = 1'b1;
                dest  = 3'd7;
            end
            default: ;
        endcase
    end

`ifdef DECODE_BYPASS_EN
    // A writeback landing this cycle both releases the source and supplies its value.
    always_comb begin
        rs_clear = wb_en && (wb_reg == rs_idx);
        rt_clear = wb_en && (wb_reg == rt_idx);
        rs_val   = rs_clear ? wb_data : rf_q[rs_idx];
        rt_val   = rt_clear ? wb_data : rf_q[rt_idx];
    end
`else
    always_comb begin
        rs_clear = 1'b0;
        rt_clear = 1'b0;
        rs_val   = rf_q[rs_idx];
        rt_val   = rf_q[rt_idx];
    end
`endif

    always_comb begin
        raw_hazard = (reads_rs && busy_q[rs_idx] && !rs_clear) ||
                     (reads_rt && busy_q[rt_idx] && !rt_clear);
        // WAW ignores same-cycle writeback so an in-flight writer is never overtaken.
        waw_hazard = wr_en && busy_q[dest];
        hazard     = raw_hazard || waw_hazard;
        instr_ready = !rst && (!ex_valid_q || ex_ready) && !hazard && !halted_q;
        issue       = instr_valid && instr_ready;
    end

    // Clear on writeback first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_reg] = 1'b0;
        end
        if (issue && wr_en) begin
            busy_d[dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                rf_q[k] <= '0;
            end
        end else if (wb_en) begin
            rf_q[wb_reg] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (issue && (opcode == 5'b00000)) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Single-entry output register: loads on issue, empties on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_funct_q  <= '0;
            ex_imm_q    <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_pc_q     <= '0;
            ex_wr_en_q  <= 1'b0;
            ex_wr_reg_q <= '0;
        end else if (issue) begin
            ex_valid_q  <= 1'b1;
            ex_opcode_q <= opcode;
            ex_funct_q  <= instr[1:0];
            ex_imm_q    <= instr[7:0];
            ex_rs_q     <= rs_val;
            ex_rt_q     <= rt_val;
            ex_pc_q     <= instr_pc;
            ex_wr_en_q  <= wr_en;
            ex_wr_reg_q <= dest;
        end else if (ex_ready) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_opcode = ex_opcode_q;
    assign ex_funct  = ex_funct_q;
    assign ex_imm    = ex_imm_q;
    assign ex_rs     = ex_rs_q;
    assign ex_rt     = ex_rt_q;
    assign ex_pc     = ex_pc_q;
    assign ex_wr_en  = ex_wr_en_q;
    assign ex_wr_reg = ex_wr_reg_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: issued bundles are queued as expectations and
// compared when the execute handshake completes.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0800;
    logic [15:0] instr_pc = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_reg = '0;
    logic [15:0] wb_data = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b1;
    logic [4:0]  ex_opcode;
    logic [1:0]  ex_funct;
    logic [7:0]  ex_imm;
    logic [15:0] ex_rs, ex_rt, ex_pc;
    logic        ex_wr_en;
    logic [2:0]  ex_wr_reg;
    logic        halted;

    typedef struct packed {
        logic [4:0]  op;
        logic [1:0]  fn;
        logic [7:0]  imm;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] pc;
        logic        wr;
        logic [2:0]  wreg;
    } bundle_t;

    bundle_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    decode_issue dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_opcode  (ex_opcode),
        .ex_funct   (ex_funct),
        .ex_imm     (ex_imm),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_pc      (ex_pc),
        .ex_wr_en   (ex_wr_en),
        .ex_wr_reg  (ex_wr_reg),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [15:0] i, input logic [15:0] rs,
                                   input logic [15:0] rt, input logic [15:0] pc,
                                   input logic wr, input logic [2:0] wreg);
        bundle_t b;
        b.op   = i[15:11];
        b.fn   = i[1:0];
        b.imm  = i[7:0];
        b.rs   = rs;
        b.rt   = rt;
        b.pc   = pc;
        b.wr   = wr;
        b.wreg = wreg;
        return b;
    endfunction

    // Drive one cycle of stimulus after the edge, check instr_ready at the falling edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [15:0] i,
                        input logic [15:0] pc, input logic we, input logic [2:0] wr,
                        input logic [15:0] wd, input logic er, input logic exp_rdy,
                        input bundle_t exp_b);
        @(posedge clk);
        #1;
        rst         = r;
        instr_valid = v;
        instr       = i;
        instr_pc    = pc;
        wb_en       = we;
        wb_reg      = wr;
        wb_data     = wd;
        ex_ready    = er;
        if (v && exp_rdy) exp_q.push_back(exp_b);
        @(negedge clk);
        check(tag, 80'(instr_ready), 80'(exp_rdy));
    endtask

    always @(negedge clk) begin
        if (ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_bundle", 80'(ex_valid), 80'(0));
            end else begin
                bundle_t e;
                bundle_t g;
                e = exp_q.pop_front();
                g = '{ex_opcode, ex_funct, ex_imm, ex_rs, ex_rt, ex_pc, ex_wr_en, ex_wr_reg};
                check("bundle", 80'(g), 80'(e));
            end
        end
    end

    localparam logic [15:0] Nop = 16'h0800;
    bundle_t nb;
    int wait_cnt;

    initial begin
        nb = '0;
        // Reset state.
        step("rst_ready", 1'b1, 1'b0, Nop, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);
        step("rst_ready2", 1'b1, 1'b0, Nop, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);
        check("rst_ex_valid", 80'(ex_valid), 80'(0));
        check("rst_halted", 80'(halted), 80'(0));
        check("rst_bundle", 80'({ex_opcode, ex_funct, ex_imm, ex_rs, ex_rt, ex_pc, ex_wr_en,
                                 ex_wr_reg}), 80'(0));

        // R3 = 0x1234, then ADD R1,R3,R3.
        step("wb_r3", 1'b0, 1'b0, Nop, 16'h0, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b1, nb);
        step("add_rdy", 1'b0, 1'b1, 16'hDB64, 16'h0102, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'hDB64, 16'h1234, 16'h1234, 16'h0102, 1'b1, 3'd1));
        step("wb_r1", 1'b0, 1'b0, Nop, 16'h0, 1'b1, 3'd1, 16'h0011, 1'b1, 1'b1, nb);

        // ADDI R2,R1,5 then SUB R4,R2,R2 stalls on R2.
        step("addi_rdy", 1'b0, 1'b1, 16'h4145, 16'h0104, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'h4145, 16'h0011, 16'h0000, 16'h0104, 1'b1, 3'd2));
        step("sub_stall", 1'b0, 1'b1, 16'hDA51, 16'h0106, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);
`ifdef DECODE_BYPASS_EN
        step("sub_bypass", 1'b0, 1'b1, 16'hDA51, 16'h0106, 1'b1, 3'd2, 16'h0007, 1'b1, 1'b1,
             mk(16'hDA51, 16'h0007, 16'h0007, 16'h0106, 1'b1, 3'd4));
`else
        step("sub_wb_stall", 1'b0, 1'b1, 16'hDA51, 16'h0106, 1'b1, 3'd2, 16'h0007, 1'b1, 1'b0,
             nb);
        step("sub_after_wb", 1'b0, 1'b1, 16'hDA51, 16'h0106, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'hDA51, 16'h0007, 16'h0007, 16'h0106, 1'b1, 3'd4));
`endif

        // ST held under back-pressure for three cycles, then released.
        step("st_rdy", 1'b0, 1'b1, 16'h8320, 16'h0108, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'h8320, 16'h1234, 16'h0011, 16'h0108, 1'b0, 3'd0));
        for (int k = 0; k < 3; k++) begin
            step("hold_ready", 1'b0, 1'b1, Nop, 16'h010A, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, nb);
            check("hold_valid", 80'(ex_valid), 80'(1));
            check("hold_op", 80'(ex_opcode), 80'(5'b10000));
            check("hold_rs", 80'(ex_rs), 80'(16'h1234));
            check("hold_pc", 80'(ex_pc), 80'(16'h0108));
        end
        step("release", 1'b0, 1'b1, Nop, 16'h010A, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(Nop, 16'h0, 16'h0, 16'h010A, 1'b0, 3'd0));

        // JAL claims R7; LBI R7 waits on WAW until after the writeback edge.
        step("jal_rdy", 1'b0, 1'b1, 16'h3000, 16'h010C, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'h3000, 16'h0, 16'h0, 16'h010C, 1'b1, 3'd7));
        step("lbi_waw", 1'b0, 1'b1, 16'hC780, 16'h010E, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);
        step("lbi_waw_wb", 1'b0, 1'b1, 16'hC780, 16'h010E, 1'b1, 3'd7, 16'h0ABC, 1'b1, 1'b0, nb);
        step("lbi_rdy", 1'b0, 1'b1, 16'hC780, 16'h010E, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'hC780, 16'h0ABC, 16'h0000, 16'h010E, 1'b1, 3'd7));

        // LD R5 with same-cycle writeback to non-busy R5: set wins.
`ifdef DECODE_BYPASS_EN
        step("ld_rdy", 1'b0, 1'b1, 16'h8BA2, 16'h0110, 1'b1, 3'd5, 16'h5555, 1'b1, 1'b1,
             mk(16'h8BA2, 16'h1234, 16'h5555, 16'h0110, 1'b1, 3'd5));
`else
        step("ld_rdy", 1'b0, 1'b1, 16'h8BA2, 16'h0110, 1'b1, 3'd5, 16'h5555, 1'b1, 1'b1,
             mk(16'h8BA2, 16'h1234, 16'h0000, 16'h0110, 1'b1, 3'd5));
`endif
        step("r5_busy", 1'b0, 1'b1, 16'hDD78, 16'h0000, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);

        // HALT issues, then the stage locks.
        step("halt_rdy", 1'b0, 1'b1, 16'h0000, 16'h0112, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'h0000, 16'h0, 16'h0, 16'h0112, 1'b0, 3'd0));
        step("halted_ready", 1'b0, 1'b1, Nop, 16'h0114, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);
        check("halted_set", 80'(halted), 80'(1));
        step("halted_ready2", 1'b0, 1'b1, Nop, 16'h0114, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);

        // Reset clears halted, scoreboard and file.
        step("rst2_ready", 1'b1, 1'b0, Nop, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, nb);
        step("post_rst_rdy", 1'b0, 1'b1, 16'hDDF0, 16'h0200, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'hDDF0, 16'h0, 16'h0, 16'h0200, 1'b1, 3'd4));
        check("rst2_halted", 80'(halted), 80'(0));
        step("st_r3_zero", 1'b0, 1'b1, 16'h8320, 16'h0202, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1,
             mk(16'h8320, 16'h0, 16'h0, 16'h0202, 1'b0, 3'd0));
        step("idle", 1'b0, 1'b0, Nop, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, nb);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("drain_left", 80'(exp_q.size()), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
